uart_rx_monitor: RTL

Synthesizable, parametrised UART receiver with error reporting and an output FIFO, for the miriscv test SoC. Samples the serial line with oversampling and majority vote, checks parity and stop bits, and queues each received word with its error flags behind a valid/ready stream. Replaces bench-only UART decoding with a block usable on silicon and in regression, generalised in word width, parity mode, stop-bit count, baud rate and buffering.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_monitor.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity modes, receiver FSM states
// and the canonical layout of a received word.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Error flags sit above the data so a word reads {frame_err, parity_err, data}.
  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_word_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; full/empty come from pointers carrying an extra
// wrap bit. A push into a full FIFO is dropped unless a pop frees a slot that edge.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             overrun_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             overrun_reg;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop     = ~empty & rd_ready_i;
  assign push_ok = wr_en_i & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      overrun_reg <= wr_en_i & full & ~pop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= wr_data_i;
  end

  // Head is forced to zero while empty so stale storage never shows.
  assign rd_data_o  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign rd_valid_o = ~empty;
  assign overrun_o  = overrun_reg;

endmodule

// File: rtl/uart_rx_monitor.sv
// Oversampling UART receiver: synchronizer, tick generator, framing FSM with
// parity/stop checks, and a FWFT output queue carrying error flags with each word.
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int BAUD_DIV    = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] m_data_o,
  output logic                 m_parity_err_o,
  output logic                 m_frame_err_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int BD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int OS_W   = $clog2(OVERSAMPLE);
  localparam int BI_W   = $clog2(DATA_BITS);
  localparam int WORD_W = DATA_BITS + 2;

  localparam logic [BD_W-1:0] BD_LAST = BD_W'(BAUD_DIV - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] SAMP_0  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SAMP_1  = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] SAMP_2  = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
  localparam parity_mode_e    PMODE   = parity_mode_e'(PARITY_MODE[1:0]);

  logic                 rx_meta_reg, rx_s_reg, rx_d_reg;
  logic [BD_W-1:0]      baud_cnt_reg;
  logic                 samp0_reg, samp1_reg;
  rx_state_e            state_reg, state_next;
  logic [OS_W-1:0]      os_cnt_reg, os_cnt_next;
  logic [BI_W-1:0]      bit_idx_reg, bit_idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 tick, start_det, decide, bit_end, maj, exp_parity, push;
  logic [WORD_W-1:0]    push_word, head_word;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_d_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx_i;
      rx_s_reg    <= rx_meta_reg;
      rx_d_reg    <= rx_s_reg;
    end
  end

  assign start_det = (state_reg == IDLE) & rx_d_reg & ~rx_s_reg;
  assign tick      = (baud_cnt_reg == BD_LAST);

  // Restarting the divider on the start edge keeps sample points centred.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_det || tick) baud_cnt_reg <= '0;
    else                            baud_cnt_reg <= baud_cnt_reg + BD_W'(1);
  end

  assign decide     = tick && (os_cnt_reg == SAMP_2);
  assign bit_end    = tick && (os_cnt_reg == OS_LAST);
  assign maj        = maj3(samp0_reg, samp1_reg, rx_s_reg);
  assign exp_parity = (PMODE == ODD) ? ~^data_reg : ^data_reg;
  assign push_word  = {frame_err_reg | ~maj, parity_err_reg, data_reg};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      os_cnt_reg     <= '0;
      bit_idx_reg    <= '0;
      stop_idx_reg   <= 1'b0;
      data_reg       <= '0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      samp0_reg      <= 1'b1;
      samp1_reg      <= 1'b1;
    end else begin
      state_reg      <= state_next;
      os_cnt_reg     <= os_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      stop_idx_reg   <= stop_idx_next;
      data_reg       <= data_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
      if (tick && os_cnt_reg == SAMP_0) samp0_reg <= rx_s_reg;
      if (tick && os_cnt_reg == SAMP_1) samp1_reg <= rx_s_reg;
    end
  end

  always_comb begin
    state_next      = state_reg;
    os_cnt_next     = os_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    stop_idx_next   = stop_idx_reg;
    data_next       = data_reg;
    parity_err_next = parity_err_reg;
    frame_err_next  = frame_err_reg;
    push            = 1'b0;
    if (tick) os_cnt_next = (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + OS_W'(1);

    case (state_reg)
      IDLE: begin
        if (start_det) begin
          state_next      = START;
          os_cnt_next     = '0;
          bit_idx_next    = '0;
          stop_idx_next   = 1'b0;
          data_next       = '0;
          parity_err_next = 1'b0;
          frame_err_next  = 1'b0;
        end
      end
      START: begin
        if (decide && maj)  state_next = IDLE;
        else if (bit_end)   state_next = DATA;
      end
      DATA: begin
        if (decide) data_next[bit_idx_reg] = maj;
        if (bit_end) begin
          if (bit_idx_reg == BI_LAST) state_next = (PMODE != NONE) ? PARITY : STOP;
          else                        bit_idx_next = bit_idx_reg + BI_W'(1);
        end
      end
      PARITY: begin
        if (decide)  parity_err_next = (maj != exp_parity);
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        // The final stop bit is committed at its decision point so a start
        // edge immediately following it is not missed.
        if (decide && stop_idx_reg == STOP_LAST) begin
          push       = 1'b1;
          state_next = IDLE;
        end else begin
          if (decide)  frame_err_next = frame_err_reg | ~maj;
          if (bit_end) stop_idx_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_data_i (push_word),
    .wr_en_i   (push),
    .rd_data_o (head_word),
    .rd_valid_o(m_valid_o),
    .rd_ready_i(m_ready_i),
    .overrun_o (overrun_o)
  );

  assign m_data_o       = head_word[DATA_BITS-1:0];
  assign m_parity_err_o = head_word[DATA_BITS];
  assign m_frame_err_o  = head_word[DATA_BITS+1];
  assign busy_o         = (state_reg != IDLE);

endmodule
